ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
- Initiator-side controller for the 32x8 combinational RAM: owns the RAM's addr/data_in/we pins and reads data_out.
- Gives the CPU datapath a registered valid/ready load/store port.
- Runs a hardware clear after reset and an on-demand fill of the whole array.
- Sits between the CPU memory stage and the RAM instance. All RAM-side outputs are registered, so the RAM only ever sees stable, glitch-free addr/we.

Parameters:
ADDR_W, 5, RAM address width; DEPTH = 2**ADDR_W locations
DATA_W, 8, RAM word width
INIT_CLEAR, 1, 1 = write zero to every location after reset; 0 = go straight to IDLE

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  CPU request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  store data
rsp_valid  output  1  one-cycle pulse: access complete
rsp_rdata  output  DATA_W  load data (for stores, the value written)
fill_start  input  1  start whole-array fill, sampled in IDLE only
fill_value  input  DATA_W  fill pattern, latched on fill_start
fill_done  output  1  one-cycle pulse after last fill write
busy  output  1  high in every state except IDLE
ram_addr  output  ADDR_W  to RAM addr
ram_data_in  output  DATA_W  to RAM data_in
ram_we  output  1  to RAM we
ram_data_out  input  DATA_W  from RAM data_out (combinational read)

Behaviour:
- Reset: synchronous active-low on one clock, as already decided. While rst_n=0 at a rising edge, all state and outputs are forced as follows:
  - state = INIT if INIT_CLEAR=1, else IDLE
  - req_ready=0, rsp_valid=0, rsp_rdata=0, fill_done=0
  - ram_addr=0, ram_data_in=0, ram_we=0, busy=1
- Reset mid-operation: asserting rst_n low during any state aborts it immediately; no rsp_valid or fill_done is emitted.
- Every output is a register; nothing is combinational from an input.
- States: INIT, IDLE, ACCESS, RESP, FILL.
- INIT: walks ram_addr 0..DEPTH-1, one address per cycle, with ram_we=1 and ram_data_in=0. This takes exactly DEPTH cycles, then goes to IDLE.
- IDLE: req_ready=1, busy=0, ram_we=0. ram_addr and ram_data_in hold their last values.
  - fill_start=1 (has priority over req_valid): latch fill_value and go to FILL. The request is not accepted (req_ready already low next cycle).
  - Else req_valid=1: accept (req_ready=1 at the same edge). Register ram_addr=req_addr, ram_data_in=req_wdata, ram_we=req_we. Go to ACCESS.
- ACCESS (1 cycle): RAM pins are stable. At the end of the cycle:
  - capture rsp_rdata = ram_data_out for loads, req_wdata for stores
  - drive ram_we=0 and go to RESP
- RESP (1 cycle): rsp_valid=1, then go to IDLE.
- Load/store latency: request accepted at edge E, rsp_valid high in the cycle after edge E+2. Maximum throughput is one request per 3 cycles.
- ram_we is high for exactly one cycle per store, never for loads.
- FILL: same address walk as INIT but writing the latched fill_value; DEPTH cycles. On the final write, fill_done is pulsed in the first IDLE cycle.
- Address wrap: the INIT/FILL counter is ADDR_W+1 bits. Termination is at count==DEPTH, and ram_addr never wraps past DEPTH-1 during a walk.
- Inputs outside IDLE are ignored: req_valid, fill_start and fill_value have no effect and are not queued.
- The CPU must hold req_* stable until the req_ready handshake; the controller samples them only at the accepting edge.

Test Plan:
1. Reset then release, INIT_CLEAR=1 -> ram_we=1 for exactly 32 consecutive cycles, ram_addr 0..31, ram_data_in=0; then busy=0 and req_ready=1 on cycle 33.
2. Store 0xA5 to addr 7, then load addr 7 -> store gives a rsp_valid pulse with rsp_rdata=0xA5 and a single ram_we cycle at addr 7; load gives rsp_rdata=0xA5 with ram_we never high; each rsp_valid occurs 2 cycles after acceptance.
3. Load addr 31 and addr 0 after clear -> rsp_rdata=0x00 both. Store 0xFF to addr 31 then load it -> 0xFF, and addr 30 still reads 0x00 (no wrap corruption).
4. fill_start with fill_value=0x3C and req_valid both asserted in IDLE -> fill wins, req_ready low, 32 writes of 0x3C, fill_done pulse; a subsequent load of addr 12 returns 0x3C; the ignored request is not serviced.
5. Assert rst_n=0 for 1 cycle mid-FILL at addr 10 -> ram_we=0 next cycle, no fill_done, INIT restarts at addr 0; a final load of addr 20 returns 0x00.
6. req_valid held high continuously with 4 queued loads -> exactly one acceptance per 3 cycles, 4 rsp_valid pulses, req_ready low in ACCESS/RESP.

Source files
------------

// File: rtl/ram_ctrl_if.sv
// CPU-side port of the RAM controller: load/store request/response handshake
// plus the whole-array fill control and status.
interface ram_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              fill_start;
  logic [DATA_W-1:0] fill_value;
  logic              fill_done;
  logic              busy;

  // CPU side drives requests and fill commands
  modport master (
    output req_valid, req_we, req_addr, req_wdata, fill_start, fill_value,
    input  req_ready, rsp_valid, rsp_rdata, fill_done, busy
  );

  // Controller side answers them
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, fill_start, fill_value,
    output req_ready, rsp_valid, rsp_rdata, fill_done, busy
  );
endinterface

// File: rtl/ram_ctrl.sv
// Initiator-side controller for a small combinational-read RAM. Offers the CPU
// a registered load/store handshake, clears the array after reset and fills
// it with a pattern on demand. Every output, including all RAM pins, is a flop.
module ram_ctrl #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 8,
  parameter int INIT_CLEAR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_ctrl_if.slave         bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_data_out
);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_ACCESS = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_FILL   = 3'd4;

  // Walk counter is one bit wider than the address so the end of the array
  // is seen as count == DEPTH without the address ever wrapping.
  localparam logic [ADDR_W:0] CNT_END = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              fill_done_q, fill_done_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_data_in_q, ram_data_in_d;
  logic              ram_we_q, ram_we_d;

  // Next-state and next-output logic for the controller FSM
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_val_d    = fill_val_q;
    req_ready_d   = req_ready_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = rsp_rdata_q;
    fill_done_d   = 1'b0;
    busy_d        = busy_q;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    ram_we_d      = ram_we_q;
    case (state_q)
      S_INIT: begin
        if (cnt_q == CNT_END) begin
          state_d     = S_IDLE;
          ram_we_d    = 1'b0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          ram_we_d      = 1'b1;
          ram_addr_d    = cnt_q[ADDR_W-1:0];
          ram_data_in_d = '0;
          cnt_d         = cnt_q + CNT_ONE;
        end
      end
      S_IDLE: begin
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        ram_we_d    = 1'b0;
        if (bus.fill_start) begin
          // First fill write is issued at the start edge so the walk is DEPTH cycles
          state_d       = S_FILL;
          fill_val_d    = bus.fill_value;
          ram_we_d      = 1'b1;
          ram_addr_d    = '0;
          ram_data_in_d = bus.fill_value;
          cnt_d         = CNT_ONE;
          req_ready_d   = 1'b0;
          busy_d        = 1'b1;
        end else if (bus.req_valid && req_ready_q) begin
          state_d       = S_ACCESS;
          ram_addr_d    = bus.req_addr;
          ram_data_in_d = bus.req_wdata;
          ram_we_d      = bus.req_we;
          req_ready_d   = 1'b0;
          busy_d        = 1'b1;
        end
      end
      S_ACCESS: begin
        // Stores echo the written word; loads take the combinational read
        rsp_rdata_d = ram_we_q ? ram_data_in_q : ram_data_out;
        ram_we_d    = 1'b0;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_d = 1'b1;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
      S_FILL: begin
        if (cnt_q == CNT_END) begin
          state_d     = S_IDLE;
          ram_we_d    = 1'b0;
          fill_done_d = 1'b1;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          ram_we_d      = 1'b1;
          ram_addr_d    = cnt_q[ADDR_W-1:0];
          ram_data_in_d = fill_val_q;
          cnt_d         = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = S_IDLE;
        ram_we_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in progress
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= (INIT_CLEAR != 0) ? S_INIT : S_IDLE;
      cnt_q         <= '0;
      fill_val_q    <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      fill_done_q   <= 1'b0;
      busy_q        <= 1'b1;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
      ram_we_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_val_q    <= fill_val_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      fill_done_q   <= fill_done_d;
      busy_q        <= busy_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
      ram_we_q      <= ram_we_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.fill_done = fill_done_q;
  assign bus.busy      = busy_q;
  assign ram_addr      = ram_addr_q;
  assign ram_data_in   = ram_data_in_q;
  assign ram_we        = ram_we_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural 32x8 RAM, scoreboard of expected responses.
module tb_ram_ctrl;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_data_in;
  logic [DATA_W-1:0] ram_data_out;
  logic              ram_we;
  logic [DATA_W-1:0] mem [0:DEPTH-1] = '{default: 8'hEE};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DATA_W-1:0] exp_q [$];

  ram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .INIT_CLEAR(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .ram_addr     (ram_addr),
    .ram_data_in  (ram_data_in),
    .ram_we       (ram_we),
    .ram_data_out (ram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data_in;
  assign ram_data_out = mem[ram_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One transaction: present, wait for handshake, push expectation, wait response
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] expv,
                         output logic [DATA_W-1:0] got, output logic [DATA_W-1:0] exp,
                         output int lat, output int we_cnt,
                         output logic [ADDR_W-1:0] we_addr, output bit ok);
    int acc;
    got = '0; exp = '0; lat = 0; we_cnt = 0; we_addr = '0; ok = 1'b0; acc = 0;
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk); #1;
      acc = cyc;
      exp_q.push_back(expv);
    end
    bus.req_valid = 1'b0;
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (ram_we) begin we_cnt++; we_addr = ram_addr; end
        if (bus.rsp_valid) begin got = bus.rsp_rdata; lat = cyc - acc; ok = 1'b1; break; end
      end
      if (exp_q.size() > 0) exp = exp_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    bus.fill_start = 1'b0; bus.fill_value = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.rsp_valid, bus.fill_done, ram_we, bus.busy} !== 5'b00001) begin
      errors++;
      $display("FAIL reset_ctrl: {ready,rsp,done,we,busy}=%b expected 00001",
               {bus.req_ready, bus.rsp_valid, bus.fill_done, ram_we, bus.busy});
    end
    checks++;
    if (bus.rsp_rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", bus.rsp_rdata); end
    checks++;
    if (ram_addr !== 5'd0 || ram_data_in !== 8'h00) begin
      errors++; $display("FAIL reset_ram_pins: addr %0d data %h expected 0/00", ram_addr, ram_data_in);
    end
  endtask

  task automatic test_init_clear();
    int bad;
    bad = 0;
    rst_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      if (ram_we !== 1'b1 || ram_addr !== i[ADDR_W-1:0] || ram_data_in !== 8'h00 || bus.busy !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL init_walk: %0d bad cycles expected 0", bad); end
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.req_ready, ram_we} !== 3'b010) begin
      errors++; $display("FAIL init_end: {busy,ready,we}=%b expected 010", {bus.busy, bus.req_ready, ram_we});
    end
  endtask

  task automatic test_store_load();
    logic [DATA_W-1:0] got, exp; int lat, wc; logic [ADDR_W-1:0] wa; bit ok;
    run_txn(1'b1, 5'd7, 8'hA5, 8'hA5, got, exp, lat, wc, wa, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL store7_rdata: got %h ok %0d expected %h", got, ok, exp); end
    checks++;
    if (wc != 1 || wa !== 5'd7) begin errors++; $display("FAIL store7_we: %0d pulses at %0d expected 1 at 7", wc, wa); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL store7_latency: got %0d expected 2", lat); end
    run_txn(1'b0, 5'd7, 8'h00, 8'hA5, got, exp, lat, wc, wa, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL load7_rdata: got %h ok %0d expected %h", got, ok, exp); end
    checks++;
    if (wc != 0) begin errors++; $display("FAIL load7_we: %0d pulses expected 0", wc); end
    checks++;
    if (lat != 2) begin errors++; $display("FAIL load7_latency: got %0d expected 2", lat); end
  endtask

  task automatic test_boundary();
    logic [DATA_W-1:0] got, exp; int lat, wc; logic [ADDR_W-1:0] wa; bit ok;
    logic [ADDR_W-1:0] addrs [5];
    logic              wes [5];
    logic [DATA_W-1:0] vals [5];
    addrs = '{5'd31, 5'd0, 5'd31, 5'd31, 5'd30};
    wes   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vals  = '{8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00};
    for (int k = 0; k < 5; k++) begin
      run_txn(wes[k], addrs[k], vals[k], vals[k], got, exp, lat, wc, wa, ok);
      checks++;
      if (!ok || got !== exp) begin
        errors++; $display("FAIL boundary_%0d addr %0d: got %h ok %0d expected %h", k, addrs[k], got, ok, exp);
      end
    end
  endtask

  task automatic test_fill_priority();
    int wcnt, bad, rsp_seen; bit done;
    logic [DATA_W-1:0] got, exp; int lat, wc; logic [ADDR_W-1:0] wa; bit ok;
    wcnt = 0; bad = 0; rsp_seen = 0; done = 1'b0;
    bus.fill_start = 1'b1; bus.fill_value = 8'h3C;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_addr = 5'd5; bus.req_wdata = 8'h77;
    @(posedge clk); #1;
    bus.fill_start = 1'b0; bus.fill_value = 8'h99; bus.req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL fill_ready: got %b expected 0", bus.req_ready); end
    for (int i = 0; i < 100; i++) begin
      if (ram_we) begin
        if (ram_data_in !== 8'h3C || ram_addr !== wcnt[ADDR_W-1:0]) bad++;
        wcnt++;
      end
      if (bus.rsp_valid) rsp_seen++;
      if (bus.fill_done) begin done = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!done) begin errors++; $display("FAIL fill_done: got no pulse expected one"); end
    checks++;
    if (wcnt != DEPTH || bad != 0) begin errors++; $display("FAIL fill_writes: %0d writes %0d bad expected 32/0", wcnt, bad); end
    checks++;
    if (rsp_seen != 0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL fill_end: rsp %0d ready %b expected 0/1", rsp_seen, bus.req_ready);
    end
    run_txn(1'b0, 5'd12, 8'h00, 8'h3C, got, exp, lat, wc, wa, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL fill_load12: got %h expected %h", got, exp); end
    run_txn(1'b0, 5'd5, 8'h00, 8'h3C, got, exp, lat, wc, wa, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL fill_ignored_req: addr5 got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W-1:0] got, exp; int lat, wc; logic [ADDR_W-1:0] wa; bit ok;
    logic [ADDR_W-1:0] addrs [4];
    logic [DATA_W-1:0] vals [4];
    int n_acc, n_rsp, last_acc, bad_gap, bad_ready; bit acc_now;
    addrs = '{5'd1, 5'd2, 5'd3, 5'd4};
    vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
    n_acc = 0; n_rsp = 0; last_acc = 0; bad_gap = 0; bad_ready = 0;
    for (int k = 0; k < 4; k++) begin
      run_txn(1'b1, addrs[k], vals[k], vals[k], got, exp, lat, wc, wa, ok);
      checks++;
      if (!ok || got !== exp) begin errors++; $display("FAIL b2b_store_%0d: got %h expected %h", k, got, exp); end
    end
    @(posedge clk); #1;
    bus.req_we = 1'b0; bus.req_addr = addrs[0]; bus.req_valid = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 60 && n_rsp < 4; c++) begin
      if (bus.rsp_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_unexpected_rsp: got %h expected none", bus.rsp_rdata);
        end else begin
          exp = exp_q.pop_front();
          if (bus.rsp_rdata !== exp) begin
            errors++; $display("FAIL b2b_load_%0d: got %h expected %h", n_rsp, bus.rsp_rdata, exp);
          end
        end
        n_rsp++;
      end
      if (n_acc > 0 && (cyc - last_acc) < 2 && bus.req_ready) bad_ready++;
      acc_now = bus.req_valid && bus.req_ready;
      @(posedge clk); #1;
      if (acc_now) begin
        if (n_acc > 0 && (cyc - last_acc) != 3) bad_gap++;
        last_acc = cyc;
        exp_q.push_back(vals[n_acc]);
        n_acc++;
        if (n_acc == 4) bus.req_valid = 1'b0;
        else bus.req_addr = addrs[n_acc];
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    checks++;
    if (n_acc != 4 || n_rsp != 4) begin errors++; $display("FAIL b2b_count: acc %0d rsp %0d expected 4/4", n_acc, n_rsp); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_gap: %0d bad spacings expected 0", bad_gap); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL b2b_ready: %0d busy cycles with ready expected 0", bad_ready); end
  endtask

  task automatic test_reset_mid_fill();
    bit found; int stray;
    logic [DATA_W-1:0] got, exp; int lat, wc; logic [ADDR_W-1:0] wa; bit ok;
    found = 1'b0; stray = 0; ok = 1'b0;
    bus.fill_start = 1'b1; bus.fill_value = 8'h5A;
    @(posedge clk); #1;
    bus.fill_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ram_we && ram_addr == 5'd10) begin found = 1'b1; break; end
    end
    checks++;
    if (!found) begin errors++; $display("FAIL midfill_reach10: got no write at 10 expected one"); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({ram_we, bus.fill_done, bus.busy} !== 3'b001) begin
      errors++; $display("FAIL midfill_abort: {we,done,busy}=%b expected 001", {ram_we, bus.fill_done, bus.busy});
    end
    @(negedge clk);
    checks++;
    if (ram_we !== 1'b1 || ram_addr !== 5'd0 || ram_data_in !== 8'h00) begin
      errors++; $display("FAIL midfill_init_restart: we %b addr %0d data %h expected 1/0/00", ram_we, ram_addr, ram_data_in);
    end
    for (int i = 0; i < 80; i++) begin
      if (bus.fill_done || bus.rsp_valid) stray++;
      if (bus.req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok || stray != 0) begin errors++; $display("FAIL midfill_recover: idle %0d stray pulses %0d expected 1/0", ok, stray); end
    run_txn(1'b0, 5'd20, 8'h00, 8'h00, got, exp, lat, wc, wa, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL midfill_load20: got %h expected %h", got, exp); end
    run_txn(1'b0, 5'd3, 8'h00, 8'h00, got, exp, lat, wc, wa, ok);
    checks++;
    if (!ok || got !== exp) begin errors++; $display("FAIL midfill_load3: got %h expected %h", got, exp); end
  endtask

  initial begin
    test_reset();
    test_init_clear();
    test_store_load();
    test_boundary();
    test_fill_priority();
    test_back_to_back();
    test_reset_mid_fill();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
